// File: rtl/elevator_pkg.sv
// ============================================================================
// Module   : elevator_pkg
// Purpose  : Shared state encoding and width helpers for the elevator
//            SCAN controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

  // Controller states; the encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  // Width of a floor index: max(1, clog2(floors)).
  function automatic int floor_width(input int floors);
    return (floors <= 2) ? 1 : $clog2(floors);
  endfunction

  // Width of the shared travel/door timer: clog2 of the larger load, min 1.
  function automatic int timer_width(input int travel, input int door);
    int m;
    m = (travel > door) ? travel : door;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_call_scan.sv
// ============================================================================
// Module   : elevator_call_scan
// Purpose  : Combinational scan of the pending-call vector relative to a
//            floor: any call above, any call below, call at the floor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module elevator_call_scan
  import elevator_pkg::*;
#(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = floor_width(FLOORS)
) (
  input  logic [FLOORS-1:0]  i_pending,
  input  logic [FLOOR_W-1:0] i_floor,
  output logic               o_above,
  output logic               o_below,
  output logic               o_here
);

  // OR-reduce the pending bits strictly above and strictly below i_floor.
  always_comb begin
    o_above = 1'b0;
    o_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i_pending[i] && (i > int'(i_floor))) o_above = 1'b1;
      if (i_pending[i] && (i < int'(i_floor))) o_below = 1'b1;
    end
  end

  assign o_here = i_pending[i_floor];

endmodule

`default_nettype wire

// File: rtl/elevator_scan_controller.sv
// ============================================================================
// Module   : elevator_scan_controller
// Purpose  : N-floor elevator controller with SCAN ordering. Latches floor
//            calls, steps the car one floor per travel interval and opens
//            the door at called floors.
// Options  : ELEVATOR_DOOR_HOLD_EN - a call at the current floor while the
//            door is open restarts the door interval.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int FLOORS        = 8,
  parameter int FLOOR_W       = floor_width(FLOORS),
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [FLOORS-1:0]  i_call_req,
  output logic [FLOOR_W-1:0] o_current_floor,
  output logic [FLOORS-1:0]  o_pending,
  output logic               o_moving_up,
  output logic               o_moving_down,
  output logic               o_door_open,
  output logic               o_busy
);

  localparam int                 c_TMR_W     = timer_width(TRAVEL_CYCLES, DOOR_CYCLES);
  localparam logic [c_TMR_W-1:0] c_TRAVEL_LD = c_TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_DOOR_LD   = c_TMR_W'(DOOR_CYCLES - 1);

  state_t               r_state;
  logic [FLOOR_W-1:0]   r_floor;
  logic [FLOORS-1:0]    r_pending;
  logic                 r_dir_up;
  logic [c_TMR_W-1:0]   r_tmr;
  logic                 r_moving_up;
  logic                 r_moving_down;
  logic                 r_door_open;

  logic                 w_above;
  logic                 w_below;
  logic                 w_here;
  logic                 w_nxt_above;
  logic                 w_nxt_below;
  logic                 w_nxt_here;
  logic                 w_hold;
  logic [FLOOR_W-1:0]   w_next_floor;
  logic [FLOORS-1:0]    w_clear;

  // Calls relative to where the car is now.
  elevator_call_scan #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_scan_cur (
    .i_pending (r_pending),
    .i_floor   (r_floor),
    .o_above   (w_above),
    .o_below   (w_below),
    .o_here    (w_here)
  );

  // Calls relative to the floor the car reaches when the travel timer expires.
  elevator_call_scan #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_scan_nxt (
    .i_pending (r_pending),
    .i_floor   (w_next_floor),
    .o_above   (w_nxt_above),
    .o_below   (w_nxt_below),
    .o_here    (w_nxt_here)
  );

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign w_hold = i_call_req[r_floor];
`else
  assign w_hold = 1'b0;
`endif

  // Neighbouring floor in the direction of travel; the car never moves past
  // either end, so the increment/decrement cannot wrap while moving.
  always_comb begin
    w_next_floor = r_floor;
    if (r_state == MOVE_UP)        w_next_floor = r_floor + FLOOR_W'(1);
    else if (r_state == MOVE_DOWN) w_next_floor = r_floor - FLOOR_W'(1);
  end

  // Served-call clear: the door floor on the edge entering DOOR and every
  // cycle while the door is open.
  always_comb begin
    w_clear = '0;
    case (r_state)
      IDLE:              if (w_here) w_clear[r_floor] = 1'b1;
      MOVE_UP, MOVE_DOWN: if ((r_tmr == '0) && w_nxt_here) w_clear[w_next_floor] = 1'b1;
      DOOR:              w_clear[r_floor] = 1'b1;
      default:           w_clear = '0;
    endcase
  end

  // Main controller: call latch, SCAN decisions, timers and registered indicators.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_floor       <= '0;
      r_pending     <= '0;
      r_dir_up      <= 1'b1;
      r_tmr         <= '0;
      r_moving_up   <= 1'b0;
      r_moving_down <= 1'b0;
      r_door_open   <= 1'b0;
    end else begin
      r_pending <= (r_pending | i_call_req) & ~w_clear;
      case (r_state)
        IDLE: begin
          if (w_here) begin
            r_state     <= DOOR;
            r_tmr       <= c_DOOR_LD;
            r_door_open <= 1'b1;
          end else if (w_above && (r_dir_up || !w_below)) begin
            r_state     <= MOVE_UP;
            r_dir_up    <= 1'b1;
            r_tmr       <= c_TRAVEL_LD;
            r_moving_up <= 1'b1;
          end else if (w_below) begin
            r_state       <= MOVE_DOWN;
            r_dir_up      <= 1'b0;
            r_tmr         <= c_TRAVEL_LD;
            r_moving_down <= 1'b1;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - c_TMR_W'(1);
          end else begin
            r_floor <= w_next_floor;
            if (w_nxt_here) begin
              r_state       <= DOOR;
              r_tmr         <= c_DOOR_LD;
              r_door_open   <= 1'b1;
              r_moving_up   <= 1'b0;
              r_moving_down <= 1'b0;
            end else if ((r_state == MOVE_UP) ? w_nxt_above : w_nxt_below) begin
              r_tmr <= c_TRAVEL_LD;
            end else begin
              r_state       <= IDLE;
              r_moving_up   <= 1'b0;
              r_moving_down <= 1'b0;
            end
          end
        end
        DOOR: begin
          if (w_hold) begin
            r_tmr <= c_DOOR_LD;
          end else if (r_tmr != '0) begin
            r_tmr <= r_tmr - c_TMR_W'(1);
          end else begin
            r_state     <= IDLE;
            r_door_open <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_current_floor = r_floor;
  assign o_pending       = r_pending;
  assign o_moving_up     = r_moving_up;
  assign o_moving_down   = r_moving_down;
  assign o_door_open     = r_door_open;
  assign o_busy          = (r_state != IDLE) || (r_pending != '0);

endmodule

`default_nettype wire

// File: tb/tb_elevator_scan_controller.sv
// ============================================================================
// Module   : tb_elevator_scan_controller
// Purpose  : Self-checking bench for elevator_scan_controller: directed
//            scenarios with literal expectations plus randomized calls
//            compared every cycle against a behavioural model.
// Options  : ELEVATOR_DOOR_HOLD_EN - must match the RTL build.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_elevator_scan_controller;

  localparam int F  = 8;
  localparam int FW = 3;
  localparam int T  = 2;
  localparam int D  = 4;

  logic          clk;
  logic          rst;
  logic [F-1:0]  i_call_req;
  logic [FW-1:0] o_current_floor;
  logic [F-1:0]  o_pending;
  logic          o_moving_up;
  logic          o_moving_down;
  logic          o_door_open;
  logic          o_busy;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  // Behavioural model: position, remaining cycles of the current floor hop,
  // remaining door-open cycles, travel sense (+1/-1/0) and last direction.
  int           m_floor;
  logic [F-1:0] m_pend;
  int           m_motion;
  int           m_move_left;
  int           m_door_left;
  bit           m_dir_up;

  elevator_scan_controller #(
    .FLOORS(F), .FLOOR_W(FW), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_call_req      (i_call_req),
    .o_current_floor (o_current_floor),
    .o_pending       (o_pending),
    .o_moving_up     (o_moving_up),
    .o_moving_down   (o_moving_down),
    .o_door_open     (o_door_open),
    .o_busy          (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_floor     = 0;
    m_pend      = '0;
    m_motion    = 0;
    m_move_left = 0;
    m_door_left = 0;
    m_dir_up    = 1'b1;
  endtask

  function automatic bit calls_beyond(input logic [F-1:0] p, input int f, input int dir);
    for (int i = 0; i < F; i++)
      if (p[i] && ((dir > 0) ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model across one clock edge with call vector c applied.
  task automatic model_step(input logic [F-1:0] c);
    logic [F-1:0] old;
    logic [F-1:0] clr;
    bit           ab;
    bit           bl;
    old = m_pend;
    clr = '0;
    ab  = calls_beyond(old, m_floor, 1);
    bl  = calls_beyond(old, m_floor, -1);
    if (m_door_left > 0) begin
      clr[m_floor] = 1'b1;
`ifdef ELEVATOR_DOOR_HOLD_EN
      if (c[m_floor]) m_door_left = D;
      else            m_door_left--;
`else
      m_door_left--;
`endif
    end else if (m_motion != 0) begin
      m_move_left--;
      if (m_move_left == 0) begin
        m_floor += m_motion;
        if (old[m_floor]) begin
          m_motion     = 0;
          m_door_left  = D;
          clr[m_floor] = 1'b1;
        end else if (calls_beyond(old, m_floor, m_motion)) begin
          m_move_left = T;
        end else begin
          m_motion = 0;
        end
      end
    end else if (old[m_floor]) begin
      m_door_left  = D;
      clr[m_floor] = 1'b1;
    end else if (ab && (m_dir_up || !bl)) begin
      m_motion = 1;  m_dir_up = 1'b1; m_move_left = T;
    end else if (bl) begin
      m_motion = -1; m_dir_up = 1'b0; m_move_left = T;
    end
    m_pend = (old | c) & ~clr;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("floor",       int'(o_current_floor), m_floor);
      chk("pending",     int'(o_pending),       int'(m_pend));
      chk("moving_up",   int'(o_moving_up),     int'(m_motion == 1));
      chk("moving_down", int'(o_moving_down),   int'(m_motion == -1));
      chk("door_open",   int'(o_door_open),     int'(m_door_left > 0));
      chk("busy",        int'(o_busy),
          int'((m_motion != 0) || (m_door_left > 0) || (m_pend != '0)));
    end
  end

  // Drive calls, take one edge, advance the model, return 1 time unit later.
  task automatic step(input logic [F-1:0] c);
    i_call_req = c;
    @(posedge clk);
    model_step(c);
    #1;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    model_reset();
    i_call_req = '0;
    #1;
    chk("rst_floor", int'(o_current_floor), 0);
    chk("rst_pend",  int'(o_pending),       0);
    chk("rst_up",    int'(o_moving_up),     0);
    chk("rst_down",  int'(o_moving_down),   0);
    chk("rst_door",  int'(o_door_open),     0);
    chk("rst_busy",  int'(o_busy),          0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return o_moving_up;
      1:       return o_moving_down;
      default: return o_door_open;
    endcase
  endfunction

  // Number of consecutive cycles (from now) the selected indicator stays high.
  task automatic count_high(input int w, output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (!sig(w)) break;
      n++;
      step('0);
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 300; k++) begin
      if (!o_busy) break;
      step('0);
    end
    if (k >= 300) chk("drain_timeout", 1, 0);
  endtask

  task automatic go_to(input int f);
    logic [F-1:0] c;
    c = '0;
    c[f] = 1'b1;
    step(c);
    drain();
  endtask

  task automatic wait_floor(input int f);
    int k;
    for (k = 0; k < 100; k++) begin
      if (int'(o_current_floor) == f) break;
      step('0);
    end
    if (k >= 100) chk("wait_floor_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [F-1:0] c;

    rst = 1'b1;
    i_call_req = '0;
    model_reset();
    #12;
    chk("reset_busy",  int'(o_busy),          0);
    chk("reset_floor", int'(o_current_floor), 0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: call at the resting floor
    step(8'h01);
    chk("t1_pend", int'(o_pending), 8'h01);
    chk("t1_door_not_yet", int'(o_door_open), 0);
    step('0);
    chk("t1_door", int'(o_door_open), 1);
    chk("t1_pend_clr", int'(o_pending), 0);
    count_high(2, n);
    chk("t1_door_len", n, 4);
    chk("t1_busy", int'(o_busy), 0);

    // 2: floor 0 to floor 3
    step(8'h08);
    step('0);
    count_high(0, n);
    chk("t2_up_len", n, 6);
    chk("t2_floor", int'(o_current_floor), 3);
    chk("t2_door", int'(o_door_open), 1);
    count_high(2, n);
    chk("t2_door_len", n, 4);
    chk("t2_pend", int'(o_pending), 0);

    // 3: up to 6, call 1 while passing 4, then reverse
    step(8'h40);
    step('0);
    wait_floor(4);
    step(8'h02);
    for (k = 0; k < 50 && o_moving_up; k++) step('0);
    chk("t3_floor6", int'(o_current_floor), 6);
    chk("t3_door6", int'(o_door_open), 1);
    count_high(2, n);
    chk("t3_door_len", n, 4);
    chk("t3_idle_gap", int'(o_moving_down), 0);
    step('0);
    count_high(1, n);
    chk("t3_down_len", n, 10);
    chk("t3_floor1", int'(o_current_floor), 1);
    chk("t3_door1", int'(o_door_open), 1);
    drain();

    // 4: simultaneous calls above and below resolve by last direction
    go_to(3);
    step(8'h22);
    step('0);
    chk("t4_up", int'(o_moving_up), 1);
    chk("t4_up_not_down", int'(o_moving_down), 0);
    drain();
    go_to(5);
    go_to(3);
    step(8'h22);
    step('0);
    chk("t4_down", int'(o_moving_down), 1);
    chk("t4_down_not_up", int'(o_moving_up), 0);
    drain();

    // 5: reset mid-move at floor 4
    go_to(0);
    step(8'h80);
    step('0);
    wait_floor(4);
    step('0);
    do_reset();
    for (int i = 0; i < 5; i++) step('0);
    chk("t5_floor", int'(o_current_floor), 0);
    chk("t5_still", int'(o_moving_up), 0);
    chk("t5_busy",  int'(o_busy), 0);

    // 6: re-call of the door floor on the 3rd open cycle
    go_to(2);
    step(8'h04);
    step('0);
    n = 0;
    for (k = 0; k < 40 && o_door_open; k++) begin
      n++;
      step((n == 3) ? 8'h04 : 8'h00);
    end
`ifdef ELEVATOR_DOOR_HOLD_EN
    chk("t6_door_len", n, 7);
`else
    chk("t6_door_len", n, 4);
`endif
    chk("t6_pend", int'(o_pending), 0);

    // Randomized traffic with occasional mid-operation resets
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 15);
      c = '0;
      if (k < 3)       c[$urandom_range(0, F - 1)] = 1'b1;
      else if (k == 3) c = F'($urandom);
      else if (k == 4 && o_door_open) c[o_current_floor] = 1'b1;
      step(c);
      if ($urandom_range(0, 599) == 0) do_reset();
    end
    drain();
    chk("final_idle", int'(o_busy), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/elevator_scan_controller.md
Name: elevator_scan_controller

Overview:
- Sequential, parametrised elevator controller generalising the combinational direction/count/floor-check logic to N floors.
- Latches floor calls, steps the car one floor per travel interval and opens the door at called floors.
- Uses SCAN ordering: keeps the current direction while calls remain ahead, then reverses.
- Top-level control block of the elevator design, driven by the call buttons and driving the motor/door indicators.

Parameters:
- FLOORS, 8, number of floors; legal 2..256.
- FLOOR_W, 3, width of a floor index; must equal max(1, clog2(FLOORS)).
- TRAVEL_CYCLES, 2, cycles spent moving per floor; at least 1.
- DOOR_CYCLES, 4, cycles the door stays open; at least 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- call_req  in  FLOORS  per-floor call pulses; any high bit is latched.
- current_floor  out  FLOOR_W  floor the car is at.
- pending  out  FLOORS  latched, unserved calls.
- moving_up  out  1  high in MOVE_UP.
- moving_down  out  1  high in MOVE_DOWN.
- door_open  out  1  high in DOOR.
- busy  out  1  (state != IDLE) or (pending != 0).

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is asynchronous and active-high.
- Reset (immediate, mid-operation included):
  - state=IDLE, current_floor=0, pending=0, dir_up=1, timers=0.
  - All outputs read 0.
- Call latching: pending <= (pending | call_req) & ~clear_mask.
  - clear_mask = one-hot of current_floor on the edge that enters DOOR, and every cycle while in DOOR.
  - If set and clear hit the same bit, clear wins, except as noted under the optional feature.
- Decision inputs, from the registered pending only:
  - above = any pending bit above current_floor.
  - below = any pending bit below current_floor.
  - here = pending[current_floor].
- IDLE:
  - here -> DOOR, load door timer with DOOR_CYCLES-1.
  - else above and (dir_up or not below) -> MOVE_UP, dir_up=1.
  - else below -> MOVE_DOWN, dir_up=0.
  - else stay in IDLE.
- Latency: call_req sampled at edge k is visible on pending after edge k. It is acted on at edge k+1, e.g. door_open is high after edge k+1.
- MOVE_UP / MOVE_DOWN:
  - The travel timer loads TRAVEL_CYCLES-1 on entry and decrements each cycle.
  - At timer 0, current_floor increments/decrements on that edge.
  - The next state uses the new floor: pending[new] -> DOOR; else calls further in the same direction -> stay and reload the timer; else IDLE.
  - A floor is traversed in exactly TRAVEL_CYCLES cycles.
- DOOR:
  - The door timer decrements each cycle; at 0 -> IDLE.
  - door_open is high for exactly DOOR_CYCLES cycles.
- Boundaries:
  - current_floor never leaves 0..FLOORS-1. MOVE_UP is never entered at FLOORS-1; MOVE_DOWN is never entered at 0.
  - A call at the floor being departed during MOVE stays pending and is served on a later visit.
  - Simultaneous calls above and below in IDLE resolve by dir_up.
- Timer widths: clog2 of the larger of TRAVEL_CYCLES and DOOR_CYCLES, minimum 1. No wrap-around is permitted.

Optional Feature:
- Macro: ELEVATOR_DOOR_HOLD_EN.
- Defined: call_req[current_floor] during DOOR reloads the door timer to DOOR_CYCLES-1, so the door stays open DOOR_CYCLES more cycles. The bit is still not latched into pending.
- Undefined: such a call is discarded (clear wins) and the door closes on schedule.

Decomposition:
- Shared package elevator_pkg holds:
  - state encodings IDLE=2'd0, MOVE_UP=2'd1, MOVE_DOWN=2'd2, DOOR=2'd3;
  - a floor-width function.
- One combinational sub-module, elevator_call_scan #(FLOORS, FLOOR_W). Inputs: pending, current_floor. Outputs: above, below, here.

Test Plan (FLOORS=8, TRAVEL_CYCLES=2, DOOR_CYCLES=4):
1. After reset, call_req=8'h01 for 1 cycle -> pending[0] high for 1 cycle; door_open high 4 cycles starting 2 cycles after the call; then IDLE, busy=0.
2. At floor 0, call floor 3 -> moving_up for 6 cycles; current_floor 1,2,3 every 2 cycles; door_open 4 cycles; pending=0.
3. Moving up to 6, call floor 1 while at floor 4 -> car reaches 6 with no stops, opens door, then moves down to 1 (dir_up=0); total 10 move cycles after the door.
4. IDLE at floor 3 with calls 5 and 1 set the same cycle -> MOVE_UP if dir_up=1; MOVE_DOWN if the last trip was downward.
5. Assert reset mid-move at floor 4 -> current_floor=0, pending=0 and all outputs 0 before the next clock edge; motion resumes only on new calls.
6. In DOOR at floor 2, pulse call_req[2] on the 3rd open cycle -> with ELEVATOR_DOOR_HOLD_EN, door_open lasts 7 cycles total; without it, 4 cycles and pending[2] stays 0.
